// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave responder over a word-addressed on-chip SRAM
// Independent write and read engines, one outstanding burst each, sharing one array.
module axi_sram_slave #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [31:0]       mem [DEPTH];
  logic [3:0]        w_id, w_len, w_beat;
  logic [MEM_AW-1:0] w_idx;
  logic              w_cfg_err, w_last_err;
  logic [3:0]        r_id, r_len, r_beat;
  logic [MEM_AW-1:0] r_idx;
  logic              r_err;
  logic              aw_hs, w_hs, ar_hs, r_hs;

  // Upper address bits alias and wid is not checked.
  logic unused_bits;
  assign unused_bits = ^{wid_i, awaddr_i[31:MEM_AW+2], awaddr_i[1:0],
                         araddr_i[31:MEM_AW+2], araddr_i[1:0]};

  assign aw_hs = awvalid_i && awready_o;
  assign w_hs  = wvalid_i && wready_o;
  assign ar_hs = arvalid_i && arready_o;
  assign r_hs  = rvalid_o && rready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next    = w_state;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bresp_o   = 2'b00;
    case (w_state)
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) w_next = W_DATA;
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i && (w_beat == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bresp_o  = (w_cfg_err || w_last_err) ? 2'b10 : 2'b00;
        if (bready_i) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    rresp_o   = 2'b00;
    rdata_o   = '0;
    case (r_state)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = (r_beat == r_len);
        rresp_o  = r_err ? 2'b10 : 2'b00;
        rdata_o  = r_err ? 32'd0 : mem[r_idx];
        if (rready_i && (r_beat == r_len)) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign bid_o = w_id;
  assign rid_o = r_id;

  // A wlast mismatch only flags the response; the beat itself is still stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id       <= '0;
      w_len      <= '0;
      w_beat     <= '0;
      w_idx      <= '0;
      w_cfg_err  <= 1'b0;
      w_last_err <= 1'b0;
    end else if (aw_hs) begin
      w_id       <= awid_i;
      w_len      <= awlen_i;
      w_beat     <= '0;
      w_idx      <= awaddr_i[MEM_AW+1:2];
      w_cfg_err  <= (awburst_i != 2'b01) || (awsize_i != 3'b010);
      w_last_err <= 1'b0;
    end else if (w_hs) begin
      w_beat <= w_beat + 4'd1;
      w_idx  <= w_idx + 1'b1;
      if (wlast_i != (w_beat == w_len)) w_last_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_idx  <= '0;
      r_err  <= 1'b0;
    end else if (ar_hs) begin
      r_id   <= arid_i;
      r_len  <= arlen_i;
      r_beat <= '0;
      r_idx  <= araddr_i[MEM_AW+1:2];
      r_err  <= (arburst_i != 2'b01) || (arsize_i != 3'b010);
    end else if (r_hs) begin
      r_beat <= r_beat + 4'd1;
      r_idx  <= r_idx + 1'b1;
    end
  end

  // Storage is never reset; contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_hs && !w_cfg_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - bench for axi_sram_slave
// Drives AXI bursts and checks every response against a word-array reference memory.
module tb_axi_sram_slave;
  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  logic        clk, rst;
  logic [3:0]  awid_i, awlen_i, wid_i, wstrb_i, bid_o, arid_i, arlen_i, rid_o;
  logic [31:0] awaddr_i, wdata_i, araddr_i, rdata_o;
  logic [2:0]  awsize_i, arsize_i;
  logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
  logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;

  axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] old0;
  logic [3:0]  rid4, rlen4;
  logic [31:0] raddr;
  logic [1:0]  rburst;
  logic [2:0]  rsize;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int bad_last,
                          input int bdelay, input bit gaps);
    int   idx;
    logic cfg_err;
    logic [1:0] exp_resp;
    idx      = int'(addr[MEM_AW+1:2]);
    cfg_err  = (burst != 2'b01) || (size != 3'b010);
    exp_resp = (cfg_err || (bad_last >= 0 && bad_last <= int'(len))) ? 2'b10 : 2'b00;
    @(posedge clk); #1;
    chk("aw_ready", 32'(awready_o), 32'd1);
    awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = size;
    awvalid_i = 1'b1;
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          wvalid_i = 1'b0;
          chk("w_gap_bvalid", 32'(bvalid_o), 32'd0);
          @(posedge clk); #1;
        end
      end
      chk("w_ready", 32'(wready_o), 32'd1);
      wvalid_i = 1'b1; wdata_i = wd[b]; wstrb_i = ws[b]; wid_i = id;
      wlast_i = (b == int'(len)) != (b == bad_last);
      if (!cfg_err) model_write(idx, wd[b], ws[b]);
      idx = (idx + 1) % DEPTH;
      @(posedge clk); #1;
    end
    wvalid_i = 1'b0; wlast_i = 1'b0;
    for (int c = 0; c <= bdelay; c++) begin
      chk("b_valid", 32'(bvalid_o), 32'd1);
      chk("b_id", 32'(bid_o), 32'(id));
      chk("b_resp", 32'(bresp_o), 32'(exp_resp));
      chk("w_ready_resp", 32'(wready_o), 32'd0);
      bready_i = (c == bdelay);
      @(posedge clk); #1;
    end
    bready_i = 1'b0;
    chk("b_done", 32'(bvalid_o), 32'd0);
    chk("aw_ready_after", 32'(awready_o), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input bit bp);
    int   idx, b, guard;
    logic err;
    idx = int'(addr[MEM_AW+1:2]);
    err = (burst != 2'b01) || (size != 3'b010);
    @(posedge clk); #1;
    chk("ar_ready", 32'(arready_o), 32'd1);
    arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arsize_i = size;
    arvalid_i = 1'b1;
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    b = 0; guard = 0;
    while (b <= int'(len) && guard < 200) begin
      chk("r_valid", 32'(rvalid_o), 32'd1);
      chk("r_id", 32'(rid_o), 32'(id));
      chk("r_resp", 32'(rresp_o), err ? 32'd2 : 32'd0);
      chk("r_last", 32'(rlast_o), 32'(b == int'(len)));
      chk("r_data", rdata_o, err ? 32'd0 : ref_mem[(idx + b) % DEPTH]);
      rready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (rready_i) b++;
      guard++;
    end
    rready_i = 1'b0;
    chk("r_beats", 32'(b), 32'(int'(len) + 1));
    chk("r_done", 32'(rvalid_o), 32'd0);
    chk("ar_ready_after", 32'(arready_o), 32'd1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_awready"}, 32'(awready_o), 32'd1);
    chk({pfx, "_arready"}, 32'(arready_o), 32'd1);
    chk({pfx, "_wready"},  32'(wready_o),  32'd0);
    chk({pfx, "_bvalid"},  32'(bvalid_o),  32'd0);
    chk({pfx, "_rvalid"},  32'(rvalid_o),  32'd0);
    chk({pfx, "_rlast"},   32'(rlast_o),   32'd0);
    chk({pfx, "_bresp"},   32'(bresp_o),   32'd0);
    chk({pfx, "_rresp"},   32'(rresp_o),   32'd0);
    chk({pfx, "_bid"},     32'(bid_o),     32'd0);
    chk({pfx, "_rid"},     32'(rid_o),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
    wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
    arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
    rready_i = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill the whole memory with random words so every later read has a known value.
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      do_write(4'($urandom), 32'(k * 64), 4'd15, 2'b01, 3'b010, -1, $urandom_range(0, 2), 1'b1);
    end

    // Single beat
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'd2, 32'h10, 4'd0, 2'b01, 3'b010, -1, 0, 1'b0);
    do_read(4'd2, 32'h10, 4'd0, 2'b01, 3'b010, 1'b0);

    // 16-beat INCR with a partial strobe on beat 3
    for (int b = 0; b < 16; b++) begin wd[b] = 32'hFFFFFFFF; ws[b] = 4'hF; end
    do_write(4'd1, 32'h100, 4'd15, 2'b01, 3'b010, -1, 0, 1'b0);
    for (int b = 0; b < 16; b++) begin wd[b] = 32'(b); ws[b] = 4'hF; end
    ws[3] = 4'b0011;
    do_write(4'd1, 32'h100, 4'd15, 2'b01, 3'b010, -1, 0, 1'b0);
    do_read(4'd1, 32'h100, 4'd15, 2'b01, 3'b010, 1'b1);

    // Unsupported burst type / size
    for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(4'd7, 32'h200, 4'd3, 2'b00, 3'b010, -1, 0, 1'b0);
    do_read(4'd7, 32'h200, 4'd3, 2'b01, 3'b010, 1'b0);
    do_read(4'd6, 32'h100, 4'd0, 2'b01, 3'b001, 1'b0);

    // Backpressure on B and R, and an early wlast
    for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(4'd9, 32'h400, 4'd3, 2'b01, 3'b010, -1, 5, 1'b1);
    do_read(4'd9, 32'h400, 4'd3, 2'b01, 3'b010, 1'b1);
    for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    do_write(4'd8, 32'h300, 4'd3, 2'b01, 3'b010, 1, 0, 1'b0);
    do_read(4'd8, 32'h300, 4'd3, 2'b01, 3'b010, 1'b0);

    // Wrap at top of memory with a concurrent read of word 0
    old0 = ref_mem[0];
    wd[0] = $urandom; wd[1] = $urandom;
    @(posedge clk); #1;
    awid_i = 4'd3; awaddr_i = 32'((DEPTH - 1) * 4); awlen_i = 4'd1; awburst_i = 2'b01;
    awsize_i = 3'b010; awvalid_i = 1'b1;
    arid_i = 4'd4; araddr_i = 32'h0; arlen_i = 4'd0; arburst_i = 2'b01; arsize_i = 3'b010;
    arvalid_i = 1'b1;
    @(posedge clk); #1;
    awvalid_i = 1'b0; arvalid_i = 1'b0;
    wvalid_i = 1'b1; wdata_i = wd[0]; wstrb_i = 4'hF; wlast_i = 1'b0; rready_i = 1'b0;
    chk("wrap_rvalid", 32'(rvalid_o), 32'd1);
    chk("wrap_rdata_pre", rdata_o, old0);
    @(posedge clk); #1;
    wdata_i = wd[1]; wlast_i = 1'b1; rready_i = 1'b1;
    chk("wrap_rdata_same_cycle", rdata_o, old0);
    @(posedge clk); #1;
    wvalid_i = 1'b0; wlast_i = 1'b0; rready_i = 1'b0;
    model_write(DEPTH - 1, wd[0], 4'hF);
    model_write(0, wd[1], 4'hF);
    chk("wrap_bvalid", 32'(bvalid_o), 32'd1);
    chk("wrap_bresp", 32'(bresp_o), 32'd0);
    chk("wrap_bid", 32'(bid_o), 32'd3);
    chk("wrap_rdone", 32'(rvalid_o), 32'd0);
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0;
    do_read(4'd4, 32'((DEPTH - 1) * 4), 4'd1, 2'b01, 3'b010, 1'b0);

    // Reset during beat 5 of an 8-beat write
    for (int b = 0; b < 8; b++) wd[b] = $urandom;
    @(posedge clk); #1;
    awid_i = 4'd5; awaddr_i = 32'(200 * 4); awlen_i = 4'd7; awburst_i = 2'b01;
    awsize_i = 3'b010; awvalid_i = 1'b1;
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      wvalid_i = 1'b1; wdata_i = wd[b]; wstrb_i = 4'hF; wlast_i = 1'b0;
      model_write(200 + b, wd[b], 4'hF);
      @(posedge clk); #1;
    end
    wdata_i = wd[5];
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    wvalid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_b", 32'(bvalid_o), 32'd0);
      @(posedge clk); #1;
    end
    do_read(4'd5, 32'(200 * 4), 4'd7, 2'b01, 3'b010, 1'b0);

    // Random mixed traffic
    for (int k = 0; k < 30; k++) begin
      rid4 = 4'($urandom); raddr = $urandom; rlen4 = 4'($urandom);
      rburst = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
      rsize  = ($urandom_range(0, 5) == 0) ? 3'b011 : 3'b010;
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
        do_write(rid4, raddr, rlen4, rburst, rsize,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
                 $urandom_range(0, 3), 1'b1);
      end else begin
        do_read(rid4, raddr, rlen4, rburst, rsize, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave responder backed by a word-addressed on-chip SRAM. It is the memory-side counterpart of the DMA engines' AXI master ports: it accepts AW/W/AR bursts, stores and returns data, and echoes transaction IDs on B/R. It is used as the subsystem's scratch memory and as the synthesizable memory target in DMA-level benches. Write and read paths are independent engines sharing one storage array.

## Interface
- MEM_AW, 10, log2 of memory depth in 32-bit words (default 1024 words = 4 KB)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- awid_i in 4, awaddr_i in 32, awlen_i in 4, awsize_i in 3, awburst_i in 2, awvalid_i in 1: write address; awready_o out 1
- wid_i in 4, wdata_i in 32, wstrb_i in 4, wlast_i in 1, wvalid_i in 1: write data; wready_o out 1
- bid_o out 4, bresp_o out 2, bvalid_o out 1: write response; bready_i in 1
- arid_i in 4, araddr_i in 32, arlen_i in 4, arsize_i in 3, arburst_i in 2, arvalid_i in 1: read address; arready_o out 1
- rid_o out 4, rdata_o out 32, rresp_o out 2, rlast_o out 1, rvalid_o out 1: read data; rready_i in 1

## Operation
- Word index = addr[MEM_AW+1:2]; upper address bits ignored (aliasing); addr[1:0] ignored.
- Supported: awburst/arburst = INCR (2'b01), size = 3'b010 (4 bytes). Any other burst/size: burst is still fully consumed, but resp = SLVERR (2'b10), no memory write, rdata = 0.
- Per beat, index increments by 1 modulo 2^MEM_AW (wraps at top of memory; no 4 KB check).
- Write FSM: W_IDLE (awready=1) -> on AW handshake latch id/index/len/err, beat_cnt=0 -> W_DATA (wready=1). Each W handshake: write bytes where wstrb[i]=1 (unless err), index++, beat_cnt++. On beat beat_cnt==awlen -> W_RESP. If wlast_i != (beat_cnt==awlen) on any beat, set err (SLVERR; data beats still written). wid_i not checked.
- W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00; on bready -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> on AR handshake latch id/index/len/err, beat_cnt=0 -> R_DATA (rvalid=1). rdata = mem[index] (0 if err), rid = latched id, rresp per err, rlast = (beat_cnt==arlen). On R handshake index++, beat_cnt++; on last beat -> R_IDLE.
- Only one outstanding burst per direction; new AW/AR not accepted until prior burst completes (B or last R handshake).
- Same-cycle write and read of same word: read beat presented in that cycle returns old data; new data visible from next cycle.
- Memory contents are not reset.

## Timing
- Reset values: awready_o=1, arready_o=1, wready_o=0, bvalid_o=0, rvalid_o=0, rlast_o=0, bresp_o=0, rresp_o=0, bid_o=0, rid_o=0, rdata_o don't care.
- AW handshake at cycle N -> wready high from N+1; one beat per cycle while wvalid.
- Last W handshake at cycle M -> bvalid high at M+1, held until bready; awready high the cycle after B handshake.
- AR handshake at cycle N -> first rvalid at N+1; one beat per cycle while rready; arready high the cycle after last R handshake.
- All outputs stable while valid high and ready low (AXI rule); rdata held under backpressure.
- Reset mid-burst: both FSMs to IDLE immediately, pending B/R dropped; beats already written remain in memory.
- Write and read engines proceed concurrently with no mutual stall.

## Test plan
- Single beat: AW id=2 addr=0x10 len=0, W 0xDEADBEEF strb=4'hF -> B id=2 OKAY at M+1; AR id=2 addr=0x10 len=0 -> R 0xDEADBEEF, rlast=1, rid=2.
- 16-beat INCR write from 0x100 data 0..15, beat 3 strb=4'b0011 over prior 0xFFFFFFFF -> read back beat 3 = 0xFFFF0003, others match; rlast only on beat 15.
- Error: awburst=FIXED len=3 -> 4 beats accepted, bresp=2'b10, memory unchanged; arsize=3'b001 -> 1 beat rdata=0, rresp=2'b10.
- Backpressure: bready low 5 cycles, rready toggling -> bvalid/rvalid/rdata/rlast stable while stalled, no beat lost or duplicated; wlast early on beat 1 of len=3 -> SLVERR.
- Wrap: write len=1 at word 1023 -> second beat lands at word 0; concurrent read of same word during write returns old value.
- Reset pulse during beat 5 of 8-beat write -> all valids 0, readies per reset values; beats 0-4 readable afterward, no B issued.
